// File: rtl/pipe_ctl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller.
// Optional feature macro: PIPE_CTL_IRQ_EN (adds interrupt entry state).
package pipe_ctl_pkg;

  localparam int SIZE_ADDR = 16;

  // Legal range of the flush window length, in cycles.
  localparam int FLUSH_LEN_MIN = 1;
  localparam int FLUSH_LEN_MAX = 7;

  localparam logic [SIZE_ADDR-1:0] IRQ_VEC_DEFAULT = 16'h0010;

`ifdef PIPE_CTL_IRQ_EN
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_IRQ   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1
  } state_t;
`endif

  // Counter value loaded on a redirect: the window length clamped to the
  // legal range, minus one because the load cycle itself is the first
  // cycle of the window.
  function automatic logic [2:0] flush_load(input int len);
    int l;
    l = (len < FLUSH_LEN_MIN) ? FLUSH_LEN_MIN :
        (len > FLUSH_LEN_MAX) ? FLUSH_LEN_MAX : len;
    return 3'(l - 1);
  endfunction

endpackage

// File: rtl/pipe_ctl.sv
// Pipeline control: stalls on memory wait and load-use hazards, and
// redirects/flushes the front end on taken branches.
// Optional feature macro: PIPE_CTL_IRQ_EN (interrupt entry with ack pulse,
// redirect to IRQ_VEC, never taken mid translate sequence).
module pipe_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int                   FLUSH_LEN = 2,
  parameter logic [SIZE_ADDR-1:0] IRQ_VEC   = IRQ_VEC_DEFAULT
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst_n,
  input  logic                 iw_mem_wait,
  input  logic                 iw_ld_use,
  input  logic                 iw_br_taken,
  input  logic [SIZE_ADDR-1:0] iw_br_pc,
  input  logic                 iw_xt_busy,
`ifdef PIPE_CTL_IRQ_EN
  input  logic                 iw_irq_req,
  output logic                 ow_irq_ack,
`endif
  output logic                 ow_stall_if,
  output logic                 ow_stall_xt,
  output logic                 ow_stall_id,
  output logic                 ow_flush_if,
  output logic                 ow_flush_xt,
  output logic                 ow_flush_id,
  output logic                 ow_bubble_ex,
  output logic                 ow_redirect,
  output logic [SIZE_ADDR-1:0] ow_redirect_pc
);

  localparam logic [2:0] CNT_LOAD = flush_load(FLUSH_LEN);

  state_t     state;
  logic [2:0] cnt;
  logic       flush_q;
  logic       irq_take;
  logic       hazard;

`ifdef PIPE_CTL_IRQ_EN
  // A pending interrupt waits until the translate sequence is finished.
  assign irq_take = iw_irq_req & ~iw_xt_busy;
`else
  logic xt_busy_unused;
  assign xt_busy_unused = iw_xt_busy;
  assign irq_take       = 1'b0;
`endif

  // Load-use hazard only counts when nothing of higher priority claims the cycle.
  always_comb begin
    hazard = (state == S_RUN) & iw_ld_use & ~iw_br_taken & ~irq_take;
  end

  assign ow_stall_if  = iw_mem_wait | hazard;
  assign ow_stall_xt  = iw_mem_wait | hazard;
  assign ow_stall_id  = iw_mem_wait | hazard;
  assign ow_bubble_ex = ~iw_mem_wait & hazard;

  assign ow_flush_if = flush_q;
  assign ow_flush_xt = flush_q;
  assign ow_flush_id = flush_q;

  // Control FSM: redirect launch, flush window countdown, registered pulses.
  // NOTE: state and registered outputs use non-blocking assignments so every
  // reader in this edge sees the pre-edge values.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state          <= S_RUN;
      cnt            <= 3'd0;
      flush_q        <= 1'b0;
      ow_redirect    <= 1'b0;
      // NOTE: the target register is cleared too, so a reset never leaves a
      // stale PC visible on the port.
      ow_redirect_pc <= '0;
`ifdef PIPE_CTL_IRQ_EN
      ow_irq_ack     <= 1'b0;
`endif
    end else if (!iw_mem_wait) begin
      ow_redirect    <= 1'b0;
      ow_redirect_pc <= '0;
`ifdef PIPE_CTL_IRQ_EN
      ow_irq_ack     <= 1'b0;
`endif
      if (iw_br_taken) begin
        // Last branch wins, even inside a flush window or translate sequence.
        state          <= S_FLUSH;
        cnt            <= CNT_LOAD;
        flush_q        <= 1'b1;
        ow_redirect    <= 1'b1;
        ow_redirect_pc <= iw_br_pc;
      end else if (state == S_RUN && irq_take) begin
        cnt            <= CNT_LOAD;
        flush_q        <= 1'b1;
        ow_redirect    <= 1'b1;
        ow_redirect_pc <= IRQ_VEC;
`ifdef PIPE_CTL_IRQ_EN
        state          <= S_IRQ;
        ow_irq_ack     <= 1'b1;
`else
        state          <= S_FLUSH;
`endif
      end else if (state != S_RUN) begin
        if (cnt == 3'd0) begin
          state   <= S_RUN;
          flush_q <= 1'b0;
        end else begin
          state <= S_FLUSH;
          cnt   <= cnt - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctl.sv
// Self-checking bench for pipe_ctl: directed scenarios plus randomized
// traffic compared against a flush-window model of the controller.
// Build with +define+PIPE_CTL_IRQ_EN to exercise the interrupt path.
module tb_pipe_ctl;
  import pipe_ctl_pkg::*;

  localparam int                   FLUSH_LEN = 2;
  localparam logic [SIZE_ADDR-1:0] IRQ_VEC   = 16'h0010;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 mw    = 1'b0;
  logic                 ld    = 1'b0;
  logic                 br    = 1'b0;
  logic                 xt    = 1'b0;
  logic                 irq   = 1'b0;
  logic [SIZE_ADDR-1:0] br_pc = '0;

  logic                 stall_if, stall_xt, stall_id;
  logic                 flush_if, flush_xt, flush_id;
  logic                 bubble_ex, redirect, ack_w;
  logic [SIZE_ADDR-1:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining cycles of the flush window plus the pulses
  // expected to be visible this cycle.
  int                   flush_left = 0;
  logic                 m_redirect = 1'b0;
  logic                 m_ack      = 1'b0;
  logic [SIZE_ADDR-1:0] m_pc       = '0;

  always #5 clk = ~clk;

  pipe_ctl #(.FLUSH_LEN(FLUSH_LEN), .IRQ_VEC(IRQ_VEC)) dut (
    .iw_clk        (clk),
    .iw_rst_n      (rst_n),
    .iw_mem_wait   (mw),
    .iw_ld_use     (ld),
    .iw_br_taken   (br),
    .iw_br_pc      (br_pc),
    .iw_xt_busy    (xt),
`ifdef PIPE_CTL_IRQ_EN
    .iw_irq_req    (irq),
    .ow_irq_ack    (ack_w),
`endif
    .ow_stall_if   (stall_if),
    .ow_stall_xt   (stall_xt),
    .ow_stall_id   (stall_id),
    .ow_flush_if   (flush_if),
    .ow_flush_xt   (flush_xt),
    .ow_flush_id   (flush_id),
    .ow_bubble_ex  (bubble_ex),
    .ow_redirect   (redirect),
    .ow_redirect_pc(redirect_pc)
  );

`ifndef PIPE_CTL_IRQ_EN
  assign ack_w = 1'b0;
`endif

  // {stalls[24:22], flushes[21:19], bubble[18], redirect[17], ack[16], pc[15:0]}
  logic [24:0] obs;
  assign obs = {stall_if, stall_xt, stall_id, flush_if, flush_xt, flush_id,
                bubble_ex, redirect, ack_w, redirect_pc};

  function automatic logic irq_ok();
`ifdef PIPE_CTL_IRQ_EN
    return irq && !xt;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [24:0] model_out();
    logic hz, st, fl;
    hz = (flush_left == 0) && ld && !br && !irq_ok();
    st = mw || hz;
    fl = (flush_left > 0);
    return {st, st, st, fl, fl, fl, !mw && hz, m_redirect, m_ack, m_pc};
  endfunction

  task automatic model_reset();
    flush_left = 0;
    m_redirect = 1'b0;
    m_ack      = 1'b0;
    m_pc       = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!mw) begin
      m_redirect = 1'b0;
      m_ack      = 1'b0;
      m_pc       = '0;
      if (br) begin
        m_redirect = 1'b1;
        m_pc       = br_pc;
        flush_left = FLUSH_LEN;
      end else if (flush_left == 0 && irq_ok()) begin
        m_redirect = 1'b1;
        m_ack      = 1'b1;
        m_pc       = IRQ_VEC;
        flush_left = FLUSH_LEN;
      end else if (flush_left > 0) begin
        flush_left--;
      end
    end
  endtask

  // Apply inputs just after the falling edge and let combinational logic settle.
  task automatic drive(input logic m, input logic l, input logic b,
                       input logic x, input logic q, input logic [SIZE_ADDR-1:0] pc);
    mw = m; ld = l; br = b; xt = x; irq = q; br_pc = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, '0);
    checks++;
    if (obs !== 25'h0) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", obs, 25'h0);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, '0);
      checks++;
      if (obs !== 25'h0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: got %h expected %h", i, obs, 25'h0);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [24:0] exp [4];
    exp[0] = 25'h0;
    exp[1] = {3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 16'h0123};
    exp[2] = {3'b000, 3'b111, 3'b000, 16'h0000};
    exp[3] = {3'b111, 3'b000, 1'b1, 2'b00, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(0, 0, 1, 1, 0, 16'h0123);  // xt busy must not block a branch
        3:       drive(0, 1, 0, 0, 0, '0);        // back in run: load-use stalls again
        default: drive(0, 0, 0, 0, 0, '0);
      endcase
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL branch[%0d]: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, '0);
    tick();
  endtask

  task automatic test_ld_use();
    logic [24:0] exp [3];
    exp[0] = {3'b111, 3'b000, 1'b1, 2'b00, 16'h0000};
    exp[1] = 25'h0;
    exp[2] = 25'h0;
    for (int i = 0; i < 3; i++) begin
      drive(0, i == 0, 0, 0, 0, '0);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL ld_use[%0d]: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    logic [24:0] exp;
    for (int c = 1; c <= 8; c++) begin
      case (c)
        3, 5:    drive(1, 0, 0, 0, 0, '0);
        4:       drive(1, 1, 1, 0, 1, 16'h0abc);  // everything ignored under wait
        6:       drive(0, 0, 1, 0, 0, 16'h0456);
        default: drive(0, 0, 0, 0, 0, '0);
      endcase
      case (c)
        3, 4, 5: exp = {3'b111, 22'h0};
        7:       exp = {3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 16'h0456};
        8:       exp = {3'b000, 3'b111, 3'b000, 16'h0000};
        default: exp = 25'h0;
      endcase
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mem_wait[c%0d]: got %h expected %h", c, obs, exp);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, '0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [24:0] exp [5];
    exp[0] = 25'h0;
    exp[1] = {3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 16'h1111};
    exp[2] = {3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 16'h2222};
    exp[3] = {3'b000, 3'b111, 3'b000, 16'h0000};
    exp[4] = 25'h0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(0, 0, 1, 0, 0, 16'h1111);
        1:       drive(0, 1, 1, 0, 0, 16'h2222);  // ld_use ignored in flush
        default: drive(0, 0, 0, 0, 0, '0);
      endcase
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
  endtask

`ifdef PIPE_CTL_IRQ_EN
  task automatic test_irq();
    logic [24:0] exp;
    for (int i = 0; i < 7; i++) begin
      if (i < 3)      drive(0, 0, 0, 1, 1, '0);
      else if (i == 3) drive(0, 0, 0, 0, 1, '0);
      else            drive(0, 0, 0, 0, 0, '0);
      case (i)
        4:       exp = {3'b000, 3'b111, 1'b0, 1'b1, 1'b1, IRQ_VEC};
        5:       exp = {3'b000, 3'b111, 3'b000, 16'h0000};
        default: exp = 25'h0;
      endcase
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL irq[%0d]: got %h expected %h", i, obs, exp);
      end
      tick();
    end
  endtask
`endif

  task automatic test_reset_mid_flush();
    drive(0, 0, 1, 0, 0, 16'h0777);
    tick();
    drive(0, 0, 0, 0, 0, '0);  // first flush cycle, one more to go
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 25'h0) begin
      errors++;
      $display("FAIL reset_mid_flush: got %h expected %h", obs, 25'h0);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, '0);
      checks++;
      if (obs !== 25'h0) begin
        errors++;
        $display("FAIL after_reset_release[%0d]: got %h expected %h", i, obs, 25'h0);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [24:0] exp;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      if (!rst_n) model_reset();
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, 16'($urandom_range(0, 16'hffff)));
      exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs, exp);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_ld_use();
    test_mem_wait();
    test_back_to_back();
`ifdef PIPE_CTL_IRQ_EN
    test_irq();
`endif
    test_reset_mid_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
